// File: rtl/nabp_processing_data_path_checker_if.sv
// nabp_processing_data_path_checker_if: RAM-model and PE tap bus signals for the data path checker.
// First-error capture signals exist only when NABP_DPV_FIRST_ERR_EN is defined.
interface nabp_processing_data_path_checker_if #(
    parameter int NO_OF_PARTITIONS = 4,
    parameter int DATA_LEN         = 12,
    parameter int S_LEN            = 10
);
    logic                               tt_verify_kick;
    logic [S_LEN-1:0]                   pv_s_val;
    logic [DATA_LEN-1:0]                pv_val;
    logic                               pe_en;
    logic [DATA_LEN*NO_OF_PARTITIONS-1:0] pe_taps;
    logic                               busy;
    logic                               done;
    logic                               pass;
    logic [15:0]                        err_count;
    logic [NO_OF_PARTITIONS-1:0]        err_mask;
`ifdef NABP_DPV_FIRST_ERR_EN
    logic [$clog2(NO_OF_PARTITIONS)-1:0] first_err_pe;
    logic [15:0]                        first_err_sample;
    logic [DATA_LEN-1:0]                first_err_tap;
    logic [DATA_LEN-1:0]                first_err_prev;
`endif

    modport master (
        output tt_verify_kick, pv_s_val, pe_en, pe_taps,
        input  pv_val, busy, done, pass, err_count, err_mask
`ifdef NABP_DPV_FIRST_ERR_EN
        , input first_err_pe, first_err_sample, first_err_tap, first_err_prev
`endif
    );

    modport slave (
        input  tt_verify_kick, pv_s_val, pe_en, pe_taps,
        output pv_val, busy, done, pass, err_count, err_mask
`ifdef NABP_DPV_FIRST_ERR_EN
        , output first_err_pe, first_err_sample, first_err_tap, first_err_prev
`endif
    );
endinterface

// File: rtl/nabp_processing_data_path_checker.sv
// nabp_processing_data_path_checker: filtered-data RAM model plus PE tap step/direction sweep checker.
// Define NABP_DPV_FIRST_ERR_EN to add first-failure capture outputs.
module nabp_processing_data_path_checker #(
    parameter int NO_OF_PARTITIONS = 4,
    parameter int DATA_LEN         = 12,
    parameter int S_LEN            = 10,
    parameter int RAM_LATENCY      = 2,
    parameter int SCAN_LEN         = 256,
    parameter int MAX_STEP         = 1
) (
    input logic clk,
    input logic reset,
    nabp_processing_data_path_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_POS, DIR_NEG} dir_t;

    logic [S_LEN-1:0] dl_q [RAM_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q <= '{default: '0};
        end else begin
            dl_q[0] <= bus.pv_s_val;
            for (int i = 1; i < RAM_LATENCY; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    generate
        if (S_LEN >= DATA_LEN) begin : g_trunc
            assign bus.pv_val = dl_q[RAM_LATENCY-1][DATA_LEN-1:0];
        end else begin : g_ext
            assign bus.pv_val = {{(DATA_LEN-S_LEN){1'b0}}, dl_q[RAM_LATENCY-1]};
        end
    endgenerate

    state_t                      state_q, state_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [15:0]                 err_count_q, err_count_d;
    logic [NO_OF_PARTITIONS-1:0] err_mask_q, err_mask_d;
    logic                        pass_q, pass_d;
    logic [DATA_LEN-1:0]         prev_q [NO_OF_PARTITIONS];
    logic [DATA_LEN-1:0]         prev_d [NO_OF_PARTITIONS];
    dir_t                        dir_q [NO_OF_PARTITIONS];
    dir_t                        dir_d [NO_OF_PARTITIONS];
    logic [DATA_LEN-1:0]         tap [NO_OF_PARTITIONS];
    logic [DATA_LEN:0]           diff [NO_OF_PARTITIONS];
    logic [DATA_LEN:0]           mag [NO_OF_PARTITIONS];
    dir_t                        dir_new [NO_OF_PARTITIONS];
    logic [NO_OF_PARTITIONS-1:0] fail_v;
    logic [16:0]                 sum;

    // diff is a DATA_LEN+1 bit signed difference; its MSB is the sign
    for (genvar g = 0; g < NO_OF_PARTITIONS; g++) begin : g_pe
        assign tap[g]     = bus.pe_taps[DATA_LEN*g +: DATA_LEN];
        assign diff[g]    = {1'b0, tap[g]} - {1'b0, prev_q[g]};
        assign mag[g]     = diff[g][DATA_LEN] ? -diff[g] : diff[g];
        assign fail_v[g]  = (int'(mag[g]) > MAX_STEP) ||
                            ((|diff[g]) && ((dir_q[g] == DIR_POS && diff[g][DATA_LEN]) ||
                                            (dir_q[g] == DIR_NEG && !diff[g][DATA_LEN])));
        assign dir_new[g] = (dir_q[g] == DIR_NONE && (|diff[g])) ?
                            (diff[g][DATA_LEN] ? DIR_NEG : DIR_POS) : dir_q[g];
    end

`ifdef NABP_DPV_FIRST_ERR_EN
    localparam int PW = $clog2(NO_OF_PARTITIONS);
    logic          fe_valid_q, fe_valid_d;
    logic [PW-1:0] fe_pe_q, fe_pe_d;
    logic [15:0]   fe_sample_q, fe_sample_d;
    logic [DATA_LEN-1:0] fe_tap_q, fe_tap_d, fe_prev_q, fe_prev_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
        pass_d      = pass_q;
        prev_d      = prev_q;
        dir_d       = dir_q;
        sum         = {1'b0, err_count_q};
        for (int i = 0; i < NO_OF_PARTITIONS; i++) sum = sum + 17'(fail_v[i]);
`ifdef NABP_DPV_FIRST_ERR_EN
        fe_valid_d  = fe_valid_q;
        fe_pe_d     = fe_pe_q;
        fe_sample_d = fe_sample_q;
        fe_tap_d    = fe_tap_q;
        fe_prev_d   = fe_prev_q;
`endif
        if (bus.tt_verify_kick) begin
            state_d     = ARM;
            cnt_d       = '0;
            err_count_d = '0;
            err_mask_d  = '0;
            pass_d      = 1'b0;
            dir_d       = '{default: DIR_NONE};
`ifdef NABP_DPV_FIRST_ERR_EN
            fe_valid_d  = 1'b0;
            fe_pe_d     = '0;
            fe_sample_d = '0;
            fe_tap_d    = '0;
            fe_prev_d   = '0;
`endif
        end else begin
            case (state_q)
                ARM: if (bus.pe_en) begin
                    prev_d  = tap;
                    cnt_d   = 16'd1;
                    state_d = RUN;
                end
                RUN: if (bus.pe_en) begin
                    prev_d      = tap;
                    dir_d       = dir_new;
                    err_count_d = sum[16] ? 16'hFFFF : sum[15:0];
                    err_mask_d  = err_mask_q | fail_v;
                    cnt_d       = cnt_q + 16'd1;
                    if (cnt_d == 16'(SCAN_LEN)) begin
                        state_d = DONE;
                        pass_d  = (err_count_d == '0);
                    end
`ifdef NABP_DPV_FIRST_ERR_EN
                    if (!fe_valid_q && (|fail_v)) begin
                        fe_valid_d  = 1'b1;
                        fe_sample_d = cnt_q + 16'd1;
                        for (int i = NO_OF_PARTITIONS - 1; i >= 0; i--) begin
                            if (fail_v[i]) begin
                                fe_pe_d   = PW'(i);
                                fe_tap_d  = tap[i];
                                fe_prev_d = prev_q[i];
                            end
                        end
                    end
`endif
                end
                DONE: state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_count_q <= '0;
            err_mask_q  <= '0;
            pass_q      <= 1'b0;
            prev_q      <= '{default: '0};
            dir_q       <= '{default: DIR_NONE};
`ifdef NABP_DPV_FIRST_ERR_EN
            fe_valid_q  <= 1'b0;
            fe_pe_q     <= '0;
            fe_sample_q <= '0;
            fe_tap_q    <= '0;
            fe_prev_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
            pass_q      <= pass_d;
            prev_q      <= prev_d;
            dir_q       <= dir_d;
`ifdef NABP_DPV_FIRST_ERR_EN
            fe_valid_q  <= fe_valid_d;
            fe_pe_q     <= fe_pe_d;
            fe_sample_q <= fe_sample_d;
            fe_tap_q    <= fe_tap_d;
            fe_prev_q   <= fe_prev_d;
`endif
        end
    end

    assign bus.busy      = (state_q == ARM) || (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.err_mask  = err_mask_q;
`ifdef NABP_DPV_FIRST_ERR_EN
    assign bus.first_err_pe     = fe_pe_q;
    assign bus.first_err_sample = fe_sample_q;
    assign bus.first_err_tap    = fe_tap_q;
    assign bus.first_err_prev   = fe_prev_q;
`endif
endmodule

// File: tb/tb_nabp_processing_data_path_checker.sv
// tb_nabp_processing_data_path_checker: randomized sweeps against a sign/step reference model.
module tb_nabp_processing_data_path_checker;
    localparam int NP   = 4;
    localparam int DL   = 12;
    localparam int SL   = 10;
    localparam int SCAN = 8;

    logic clk = 0;
    logic reset = 1;
    int total = 0;
    int bad = 0;

    int plan [SCAN][NP];
    int m_cnt, m_mask, m_dir[NP], m_prev[NP];
    int m_fe_valid, m_fe_pe, m_fe_sample, m_fe_tap, m_fe_prev;

    nabp_processing_data_path_checker_if #(.NO_OF_PARTITIONS(NP), .DATA_LEN(DL), .S_LEN(SL)) bus();

    nabp_processing_data_path_checker #(
        .NO_OF_PARTITIONS(NP), .DATA_LEN(DL), .S_LEN(SL),
        .RAM_LATENCY(2), .SCAN_LEN(SCAN), .MAX_STEP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_mask = 0;
        m_fe_valid = 0; m_fe_pe = 0; m_fe_sample = 0; m_fe_tap = 0; m_fe_prev = 0;
        for (int i = 0; i < NP; i++) begin m_dir[i] = 0; m_prev[i] = 0; end
    endtask

    // one accepted sample k (0-based); sample 0 is the baseline
    task automatic model_step(input int k);
        for (int i = 0; i < NP; i++) begin
            if (k > 0) begin
                int d, s, f;
                d = plan[k][i] - m_prev[i];
                f = (d > 1 || d < -1);
                if (d != 0) begin
                    s = (d > 0) ? 1 : -1;
                    if (m_dir[i] == 0) m_dir[i] = s;
                    else if (m_dir[i] != s) f = 1;
                end
                if (f != 0) begin
                    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    m_mask |= (1 << i);
                    if (m_fe_valid == 0) begin
                        m_fe_valid = 1; m_fe_pe = i; m_fe_sample = k + 1;
                        m_fe_tap = plan[k][i]; m_fe_prev = m_prev[i];
                    end
                end
            end
            m_prev[i] = plan[k][i];
        end
    endtask

    task automatic plan_clean();
        for (int i = 0; i < NP; i++) plan[0][i] = 100 + 10 * i;
        for (int k = 1; k < SCAN; k++)
            for (int i = 0; i < NP; i++) plan[k][i] = plan[k-1][i] + int'($urandom_range(0, 1));
    endtask

    task automatic plan_random();
        int steps [10] = '{0, 0, 0, 1, 1, 1, -1, 2, -2, 3};
        for (int i = 0; i < NP; i++) plan[0][i] = int'($urandom_range(200, 3800));
        for (int k = 1; k < SCAN; k++)
            for (int i = 0; i < NP; i++) plan[k][i] = plan[k-1][i] + steps[$urandom_range(0, 9)];
    endtask

    task automatic run_sweep(input bit do_kick, input int n, input bit kick_last, input int max_gap);
        bit last, fin, ended;
        if (do_kick) begin
            bus.tt_verify_kick = 1; bus.pe_en = 0;
            tick();
            bus.tt_verify_kick = 0;
            model_reset();
            total++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.err_count !== 16'd0 || bus.err_mask !== 4'd0) begin
                bad++;
                $display("FAIL kick: busy=%b done=%b cnt=%0d mask=%b required busy=1 done=0 cnt=0 mask=0",
                         bus.busy, bus.done, bus.err_count, bus.err_mask);
            end
        end
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                bus.pe_en = 0;
                bus.pe_taps = (DL*NP)'({$urandom(), $urandom()});
                tick();
                total++;
                if (bus.done !== 1'b0 || bus.err_count !== 16'(m_cnt) || bus.err_mask !== NP'(m_mask)) begin
                    bad++;
                    $display("FAIL gap k=%0d: done=%b cnt=%0d mask=%b required done=0 cnt=%0d mask=%b",
                             k, bus.done, bus.err_count, bus.err_mask, m_cnt, NP'(m_mask));
                end
            end
            last = kick_last && (k == n - 1);
            for (int i = 0; i < NP; i++) bus.pe_taps[DL*i +: DL] = DL'(plan[k][i]);
            bus.pe_en = 1;
            bus.tt_verify_kick = last;
            tick();
            bus.tt_verify_kick = 0;
            bus.pe_en = 0;
            if (last) model_reset(); else model_step(k);
            fin = !last && (k == SCAN - 1);
            total++;
            if (bus.err_count !== 16'(m_cnt) || bus.err_mask !== NP'(m_mask)) begin
                bad++;
                $display("FAIL errs k=%0d: cnt=%0d mask=%b required cnt=%0d mask=%b",
                         k, bus.err_count, bus.err_mask, m_cnt, NP'(m_mask));
            end
            total++;
            if (bus.done !== fin || bus.busy !== !fin) begin
                bad++;
                $display("FAIL ctrl k=%0d: done=%b busy=%b required done=%b busy=%b", k, bus.done, bus.busy, fin, !fin);
            end
            if (fin) begin
                total++;
                if (bus.pass !== (m_cnt == 0)) begin
                    bad++;
                    $display("FAIL pass: got=%b required=%b", bus.pass, (m_cnt == 0));
                end
`ifdef NABP_DPV_FIRST_ERR_EN
                total++;
                if (bus.first_err_pe !== 2'(m_fe_pe) || bus.first_err_sample !== 16'(m_fe_sample) ||
                    bus.first_err_tap !== DL'(m_fe_tap) || bus.first_err_prev !== DL'(m_fe_prev)) begin
                    bad++;
                    $display("FAIL first_err: pe=%0d smp=%0d tap=%0d prev=%0d required pe=%0d smp=%0d tap=%0d prev=%0d",
                             bus.first_err_pe, bus.first_err_sample, bus.first_err_tap, bus.first_err_prev,
                             m_fe_pe, m_fe_sample, m_fe_tap, m_fe_prev);
                end
`endif
            end
        end
        ended = (n == SCAN) && !kick_last;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== !ended || (ended && bus.pass !== (m_cnt == 0))) begin
            bad++;
            $display("FAIL after: done=%b busy=%b pass=%b required done=0 busy=%b", bus.done, bus.busy, bus.pass, !ended);
        end
    endtask

    task automatic test_reset();
        reset = 1; bus.tt_verify_kick = 1; bus.pv_s_val = 5; bus.pe_en = 1; bus.pe_taps = '1;
        repeat (3) tick();
        total++;
        if (bus.pv_val !== 0 || bus.busy !== 0 || bus.done !== 0 || bus.pass !== 0 ||
            bus.err_count !== 0 || bus.err_mask !== 0) begin
            bad++;
            $display("FAIL reset: pv=%0d busy=%b done=%b pass=%b cnt=%0d mask=%b required all 0",
                     bus.pv_val, bus.busy, bus.done, bus.pass, bus.err_count, bus.err_mask);
        end
        bus.tt_verify_kick = 0; bus.pe_en = 0;
        reset = 0;
    endtask

    task automatic test_ram();
        int h[$];
        for (int j = 0; j < 22; j++) begin
            int v, e;
            v = (j == 0) ? 5 : int'($urandom_range(0, 1023));
            bus.pv_s_val = SL'(v);
            h.push_back(v);
            tick();
            e = (j >= 1) ? h[j-1] : 0;
            total++;
            if (bus.pv_val !== DL'(e)) begin
                bad++;
                $display("FAIL ram j=%0d: pv_val=%0d required=%0d", j, bus.pv_val, e);
            end
        end
    endtask

    task automatic test_clean();
        plan_clean();
        run_sweep(1, SCAN, 0, 0);
    endtask

    task automatic test_step_err();
        plan_clean();
        for (int k = 3; k < SCAN; k++) plan[k][2] = plan[k][2] + 2;
        run_sweep(1, SCAN, 0, 0);
    endtask

    task automatic test_dir_err();
        int p0 [SCAN] = '{10, 11, 12, 11, 11, 11, 11, 11};
        for (int k = 0; k < SCAN; k++)
            for (int i = 0; i < NP; i++) plan[k][i] = (i == 0) ? p0[k] : 100 + 10 * i;
        run_sweep(1, SCAN, 0, 0);
    endtask

    task automatic test_gaps_and_abort();
        plan_clean();
        run_sweep(1, SCAN, 0, 3);
        plan_random();
        run_sweep(1, 5, 1, 1);
        plan_random();
        run_sweep(0, SCAN, 0, 1);
        plan_random();
        run_sweep(1, SCAN, 1, 0);
        plan_clean();
        run_sweep(0, SCAN, 0, 0);
    endtask

    task automatic test_reset_mid();
        plan_clean();
        plan[1][1] = plan[0][1] + 3;
        for (int k = 2; k < SCAN; k++) plan[k][1] = plan[1][1];
        run_sweep(1, 3, 0, 0);
        reset = 1;
        tick();
        total++;
        if (bus.pv_val !== 0 || bus.busy !== 0 || bus.done !== 0 || bus.pass !== 0 ||
            bus.err_count !== 0 || bus.err_mask !== 0) begin
            bad++;
            $display("FAIL reset_mid: pv=%0d busy=%b done=%b pass=%b cnt=%0d mask=%b required all 0",
                     bus.pv_val, bus.busy, bus.done, bus.pass, bus.err_count, bus.err_mask);
        end
        reset = 0;
        bus.pe_en = 1;
        repeat (SCAN) begin
            bus.pe_taps = (DL*NP)'({$urandom(), $urandom()});
            tick();
            total++;
            if (bus.done !== 0 || bus.busy !== 0 || bus.err_count !== 0) begin
                bad++;
                $display("FAIL idle: done=%b busy=%b cnt=%0d required 0 0 0", bus.done, bus.busy, bus.err_count);
            end
        end
        bus.pe_en = 0;
        plan_clean();
        run_sweep(1, SCAN, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            plan_random();
            run_sweep(1, SCAN, 0, 2);
        end
    endtask

    initial begin
        bus.tt_verify_kick = 0; bus.pv_s_val = 0; bus.pe_en = 0; bus.pe_taps = '0;
        model_reset();
        test_reset();
        test_ram();
        test_clean();
        test_step_err();
        test_dir_err();
        test_gaps_and_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nabp_processing_data_path_checker.md
# nabp_processing_data_path_checker

Parametrised, self-checking stand-in for the filtered-data RAM and monitor of the processing-element tap bus. It serves each requested s value back as data after a configurable read latency. It then checks every PE tap across one line sweep for step size and direction consistency. It sits beside the processing swappables in system-level benches and in on-chip self-test builds, and reports pass/fail, an error count and a per-PE error mask.

## Interface
- NO_OF_PARTITIONS, 4: number of PEs on the tap bus.
- DATA_LEN, 12: filtered data / tap width.
- S_LEN, 10: width of the requested s value.
- RAM_LATENCY, 2: pv_s_val to pv_val delay in cycles; legal range 1..4.
- SCAN_LEN, 256: pe_en samples per sweep, including the baseline sample; must be at least 2.
- MAX_STEP, 1: largest legal absolute change of a tap between consecutive samples.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tt_verify_kick  in  1  one-cycle pulse; starts, or restarts, a sweep.
- pv_s_val  in  S_LEN  s index requested by the data path.
- pv_val  out  DATA_LEN  returned data: pv_s_val zero-extended, or truncated if S_LEN exceeds DATA_LEN.
- pe_en  in  1  tap bus valid this cycle.
- pe_taps  in  DATA_LEN*NO_OF_PARTITIONS  PE i occupies bits [DATA_LEN*(i+1)-1 : DATA_LEN*i].
- busy  out  1  high in ARM and RUN.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  valid from done onward; held until the next kick.
- err_count  out  16  saturating count of failing (PE, sample) pairs.
- err_mask  out  NO_OF_PARTITIONS  sticky per-PE error flags.

## Operation
- RAM model:
  - Delay line of RAM_LATENCY registers.
  - Always active, independent of the FSM.
- FSM states: IDLE, ARM, RUN, DONE.
  - IDLE: on kick, go to ARM. Clear err_count, err_mask, pass and the per-PE direction state.
  - ARM: on the first pe_en, latch all taps as prev[i], set sample count to 1, go to RUN. No check is made on this sample.
  - RUN, each pe_en cycle, for each PE i:
    - d = tap[i] - prev[i], computed signed with DATA_LEN+1 bits.
    - Step error if |d| > MAX_STEP.
    - Direction state per PE: 0 = unknown, + or -. The first nonzero d sets it. A later nonzero d of opposite sign is a direction error.
    - A PE fails at most once per sample, even if both errors occur.
    - prev[i] is then updated to tap[i].
  - Error update:
    - err_count += popcount of failing PEs, saturating at 0xFFFF.
    - err_mask |= failing PEs.
  - End of sweep: when the SCAN_LEN-th sample is taken, go to DONE.
  - DONE: done = 1 and pass = (updated err_count == 0) for one cycle, then go to IDLE.
- pe_en low: taps are ignored and no state changes.
- Kick in ARM, RUN or DONE: restart. Same clearing as from IDLE, next state ARM, and no done pulse for the aborted sweep.
- Kick in the same cycle as the final sample: the kick wins and the sweep is aborted.

## Timing
- Reset values:
  - pv_val, busy, done, pass, err_count and err_mask are 0.
  - State is IDLE; the delay line, prev[] and direction state are cleared.
- pv_val reflects pv_s_val sampled RAM_LATENCY edges earlier.
- A kick sampled at edge k gives busy = 1 after edge k. A pe_en sample at edge k+1 is accepted as the baseline.
- Check results sampled at edge k are visible in err_count and err_mask after edge k. There is no extra latency.
- The SCAN_LEN-th sample at edge k gives done = 1 and a valid pass after edge k. done and busy are 0 after edge k+1.
- Reset mid-sweep: return to IDLE at that edge, with no done pulse and all outputs back to reset values.

## Configuration
- NABP_DPV_FIRST_ERR_EN defined:
  - Adds outputs first_err_pe [$clog2(NO_OF_PARTITIONS)-1:0], first_err_sample [15:0], first_err_tap [DATA_LEN-1:0] and first_err_prev [DATA_LEN-1:0].
  - They capture the first failure of a sweep; if several PEs fail on that sample, the lowest-indexed one.
  - They are held until the next kick or reset and cleared by either.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
All scenarios use NO_OF_PARTITIONS=4, DATA_LEN=12, SCAN_LEN=8, MAX_STEP=1, RAM_LATENCY=2.
- Reset, then drive pv_s_val=5 -> pv_val=5 two edges later; every output 0 during reset.
- Kick, then 8 pe_en samples with PE i taps 100+10i incrementing by 0 or 1 -> done after sample 8, pass=1, err_count=0, err_mask=0.
- Same sweep with PE2 jumping +2 at sample 4 -> err_mask=4'b0100, err_count=1, pass=0.
- PE0 taps 10, 11, 12, 11 -> direction error at sample 4, err_mask=4'b0001, err_count=1; with the macro, first_err_pe=0, first_err_sample=4, first_err_tap=11, first_err_prev=12.
- pe_en low for 3 cycles mid-sweep with garbage taps -> those cycles are ignored and done still follows the 8th valid sample; a kick at sample 5 -> counters clear, no done pulse, and 8 new samples are required.
- Assert reset during RUN at sample 3 -> IDLE, no done, all outputs 0; the next kick runs a clean sweep to pass=1.
